// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: sw_reset requests in (master drives), per-channel rst_out plus all_run/busy status out (slave drives)
interface reset_sequencer_if;
  logic [0:3] sw_reset;
  logic [0:3] rst_out;
  logic all_run;
  logic busy;
  modport master(output sw_reset, input rst_out, all_run, busy);
  modport slave(input sw_reset, output rst_out, all_run, busy);
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: four-channel ASSERTED->DELAY->RUN reset sequencer; ports clk, reset (sync, active-high), bus (sw_reset in; rst_out, all_run, busy registered out)
module reset_sequencer #(
  parameter int MIN_ASSERT = 16,
  parameter int RELEASE_DELAY = 64,
  parameter bit ORDERED = 1'b1
) (
  input logic clk,
  input logic reset,
  reset_sequencer_if.slave bus
);
  localparam int W = $clog2((MIN_ASSERT > RELEASE_DELAY ? MIN_ASSERT : RELEASE_DELAY) + 1);
  localparam logic [W-1:0] MA_END = W'(MIN_ASSERT - 1);
  localparam logic [W-1:0] RD_END = W'(RELEASE_DELAY - 1);
  typedef enum logic [1:0] {ASSERTED, DELAY, RUN} state_t;
  state_t state [4];
  state_t state_n [4];
  logic [W-1:0] c [4];
  logic [W-1:0] c_n [4];
  logic up_run;
  logic all_n;
  logic busy_n;
  // Ordering looks at the lower channel's next state, so a chain of saturated
  // channels all release on the same edge.
  always_comb begin
    up_run = 1'b1;
    all_n = 1'b1;
    busy_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      state_n[i] = state[i];
      c_n[i] = c[i];
      if (bus.sw_reset[i]) begin
        state_n[i] = ASSERTED;
        c_n[i] = state[i] != ASSERTED ? '0 : c[i] == MA_END ? c[i] : c[i] + 1'b1;
      end else if (state[i] == ASSERTED) begin
        state_n[i] = c[i] == MA_END ? DELAY : ASSERTED;
        c_n[i] = c[i] == MA_END ? '0 : c[i] + 1'b1;
      end else if (state[i] == DELAY) begin
        state_n[i] = c[i] == RD_END && (!ORDERED || up_run) ? RUN : DELAY;
        c_n[i] = c[i] == RD_END ? c[i] : c[i] + 1'b1;
      end
      up_run = state_n[i] == RUN;
      all_n = all_n && state_n[i] == RUN;
      busy_n = busy_n || state_n[i] == DELAY;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      state[i] <= reset ? ASSERTED : state_n[i];
      c[i] <= reset ? '0 : c_n[i];
      bus.rst_out[i] <= reset || state_n[i] != RUN;
    end
    bus.all_run <= !reset && all_n;
    bus.busy <= !reset && busy_n;
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of unordered and ordered reset sequencers
module tb_reset_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  reset_sequencer_if u ();
  reset_sequencer_if o ();
  reset_sequencer #(.MIN_ASSERT(4), .RELEASE_DELAY(8), .ORDERED(1'b0)) dut_u (.clk(clk), .reset(reset), .bus(u.slave));
  reset_sequencer #(.MIN_ASSERT(4), .RELEASE_DELAY(8), .ORDERED(1'b1)) dut_o (.clk(clk), .reset(reset), .bus(o.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int cnt, f0, f3;
    u.sw_reset = 4'b1111;
    o.sw_reset = 4'b1111;
    tick();
    tick();
    check("rst_u", 32'(u.rst_out), 32'hf);
    check("allrun_u", 32'(u.all_run), 32'h0);
    check("busy_u", 32'(u.busy), 32'h0);
    check("rst_o", 32'(o.rst_out), 32'hf);
    reset = 1'b0;
    repeat (6) tick();
    check("swhold_rst", 32'(u.rst_out), 32'hf);
    check("swhold_busy", 32'(u.busy), 32'h0);
    u.sw_reset = 4'b0000;
    o.sw_reset = 4'b0000;
    repeat (8) tick();
    check("prerel_u", 32'(u.rst_out), 32'hf);
    check("prerel_o", 32'(o.rst_out), 32'hf);
    check("prerel_busy_o", 32'(o.busy), 32'h1);
    tick();
    check("rel_u", 32'(u.rst_out), 32'h0);
    check("rel_o", 32'(o.rst_out), 32'h0);
    check("rel_allrun_u", 32'(u.all_run), 32'h1);
    check("rel_allrun_o", 32'(o.all_run), 32'h1);
    check("rel_busy_o", 32'(o.busy), 32'h0);
    f0 = -1;
    f3 = -1;
    for (int k = 0; k < 32; k++) begin
      o.sw_reset = k == 0 ? 4'b1111 : k < 20 ? 4'b1000 : 4'b0000;
      tick();
      if (k == 12) begin
        check("ord_stall", 32'(o.rst_out), 32'hf);
        check("ord_busy", 32'(o.busy), 32'h1);
      end
      if (f0 < 0 && !o.rst_out[0]) f0 = k;
      if (f3 < 0 && !o.rst_out[3]) f3 = k;
    end
    check("ord_fall0", f0, 28);
    check("ord_fall3", f3, 28);
    check("ord_allrun", 32'(o.all_run), 32'h1);
    u.sw_reset = 4'b0010;
    tick();
    u.sw_reset = 4'b0000;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) tick();
      check($sformatf("pulse_rst%0d", k), 32'(u.rst_out), k < 12 ? 32'h2 : 32'h0);
      check($sformatf("pulse_busy%0d", k), 32'(u.busy), (k >= 4 && k < 12) ? 32'h1 : 32'h0);
    end
    cnt = 0;
    for (int k = 0; k < 32; k++) begin
      u.sw_reset = k < 20 ? 4'b0100 : 4'b0000;
      tick();
      cnt += int'(u.rst_out[1]);
    end
    check("hold_len", cnt, 28);
    check("hold_end", 32'(u.rst_out), 32'h0);
    cnt = 0;
    for (int k = 0; k < 26; k++) begin
      u.sw_reset = (k == 0 || k == 10) ? 4'b0001 : 4'b0000;
      tick();
      cnt += int'(u.rst_out[3]);
      if (k == 9) check("dly_busy", 32'(u.busy), 32'h1);
      if (k == 10) check("reassert_busy", 32'(u.busy), 32'h0);
    end
    check("reassert_len", cnt, 22);
    u.sw_reset = 4'b1111;
    tick();
    u.sw_reset = 4'b0000;
    repeat (6) tick();
    check("mid_busy", 32'(u.busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst", 32'(u.rst_out), 32'hf);
    check("mid_allrun", 32'(u.all_run), 32'h0);
    check("mid_busy0", 32'(u.busy), 32'h0);
    check("mid_rst_o", 32'(o.rst_out), 32'hf);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) check("rst_dly_busy", 32'(u.busy), 32'h1);
      if (k == 11) check("rst_prerel", 32'(u.rst_out), 32'hf);
    end
    check("rst_rel", 32'(u.rst_out), 32'h0);
    check("rst_allrun", 32'(u.all_run), 32'h1);
    check("rst_rel_o", 32'(o.rst_out), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter MIN_ASSERT, default 16: minimum cycles a channel stays in ASSERTED; legal range 1..65535.
REQ-002 SHALL have parameter RELEASE_DELAY, default 64: cycles a channel stays in DELAY before release; legal range 1..65535.
REQ-003 SHALL have parameter ORDERED, default 1: 1 enforces channel-index release order; 0 makes channels independent.
REQ-004 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-006 SHALL have port sw_reset  input  [0:3]  software reset request per channel, from the misc MMIO register, same clock domain; bit i drives channel i.
REQ-007 SHALL have port rst_out  output  [0:3]  registered reset to downstream domain i; 1 = held in reset.
REQ-008 SHALL have port all_run  output  1  registered; 1 when all four channels are in RUN.
REQ-009 SHALL have port busy  output  1  registered; 1 when any channel is in DELAY.

Function
REQ-010 SHALL keep, per channel, a state (ASSERTED, DELAY, RUN) and a counter c of width ceil(log2(max(MIN_ASSERT,RELEASE_DELAY)+1)).
REQ-011 SHALL drive rst_out[i]=1 in ASSERTED and DELAY, 0 in RUN; rst_out SHALL be a flop output, not decoded combinationally.
REQ-012 SHALL, in RUN with sw_reset[i]=1 at an edge, enter ASSERTED with c=0; rst_out[i] is 1 from that edge on (one-cycle latency from request).
REQ-013 SHALL, in ASSERTED, increment c each edge, saturating at MIN_ASSERT-1.
REQ-014 SHALL, in ASSERTED with c==MIN_ASSERT-1 and sw_reset[i]=0 at an edge, enter DELAY with c=0; otherwise remain in ASSERTED.
REQ-015 SHALL, in DELAY with sw_reset[i]=1 at an edge, return to ASSERTED with c=0 (re-assert restarts the full sequence).
REQ-016 SHALL, in DELAY, increment c each edge, saturating at RELEASE_DELAY-1.
REQ-017 SHALL, in DELAY with c==RELEASE_DELAY-1 and sw_reset[i]=0, enter RUN if ORDERED=0 or i==0 or channel i-1 is in RUN at that edge; otherwise hold in DELAY with c saturated.
REQ-018 SHALL therefore hold rst_out[i] high for exactly MIN_ASSERT+RELEASE_DELAY cycles after a one-cycle sw_reset[i] pulse in RUN, absent ordering stalls.
REQ-019 SHALL give sw_reset[i]=1 precedence over every other transition of channel i in the same cycle.
REQ-020 SHALL not let a channel leaving RUN affect channels already in RUN; ordering gates only the DELAY->RUN transition.
REQ-021 SHALL, when ORDERED=1 and channel i-1 re-enters ASSERTED while channel i is in DELAY, keep channel i in DELAY until channel i-1 reaches RUN again.
REQ-022 SHALL update all_run and busy on the same edge as the state changes they reflect.

Reset
REQ-023 SHALL, while reset=1, put every channel in ASSERTED with c=0 and drive rst_out=4'b1111, all_run=0, busy=0.
REQ-024 SHALL give reset precedence over sw_reset and all counters; reset mid-DELAY restarts the full sequence.
REQ-025 SHALL, on the first edge after reset deasserts, apply REQ-013..017 normally; with sw_reset=4'b1111 (misc register reset value) all channels stay in ASSERTED.

Verification
REQ-026 SHALL cover: MIN_ASSERT=4, RELEASE_DELAY=8, ORDERED=0, all channels RUN, 1-cycle pulse on sw_reset[2] -> rst_out[2] high exactly 12 cycles, rst_out[0,1,3] stay 0, busy high for cycles 5..12.
REQ-027 SHALL cover: same params, sw_reset[1] held high 20 cycles -> rst_out[1] high 20+8=28 cycles from first request edge.
REQ-028 SHALL cover: ORDERED=1, reset released with sw_reset=4'b1111, then sw_reset written 4'b0000 -> channels release in order 0,1,2,3 on the same edge (all waiting at saturation), all_run rises with that edge; then, with sw_reset[0] held until channel 3 is in DELAY, rst_out[3] stays 1 until rst_out[0] falls.
REQ-029 SHALL cover: channel in DELAY at c=5 gets sw_reset pulse -> returns to ASSERTED, total high time = elapsed + 12 cycles from the new pulse.
REQ-030 SHALL cover: reset asserted for one cycle mid-DELAY on all channels -> rst_out=4'b1111, all_run=0, busy=0 next cycle; with sw_reset=0, release after 12 cycles.
